// File: rtl/dmem_io_bridge.sv
// Data-memory bus bridge: routes CPU accesses to RAM or to a small bank of memory-mapped IO
// registers (filtered accelerometer, frame flag, square position for the VGA controller).
module dmem_io_bridge #(
    parameter logic [7:0]  IO_BASE    = 8'hFF,
    parameter int unsigned SAMPLE_DIV = 50000,
    parameter int unsigned AVG_LOG2   = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    output logic [31:0] q_dmem,
    output logic        ram_wEn,
    output logic [11:0] ram_addr,
    output logic [31:0] ram_dataIn,
    input  logic [31:0] ram_dataOut,
    input  logic [8:0]  accel_x_in,
    input  logic [8:0]  accel_y_in,
    input  logic        vSync,
    output logic [9:0]  sq_x,
    output logic [8:0]  sq_y
);
    localparam int unsigned ACC_W = 9 + AVG_LOG2;
    localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    typedef enum logic [3:0] {
        REG_ACCEL_X = 4'h0,
        REG_ACCEL_Y = 4'h1,
        REG_STATUS  = 4'h2,
        REG_SQ_X    = 4'h3,
        REG_SQ_Y    = 4'h4
    } reg_offset_t;

    logic              io_sel;
    logic [3:0]        offset;
    logic              io_sel_q;
    logic [31:0]       io_rdata;
    logic [31:0]       io_rdata_q;
    logic              status_rd;
    logic              frame_start;
    logic              vs_q;
    logic              frame;
    logic              valid;
    logic [DIV_W-1:0]  div_cnt;
    logic              sample_tick;
    logic [AVG_LOG2-1:0] win_cnt;
    logic              win_last;
    logic signed [ACC_W-1:0] acc_x, acc_y;
    logic signed [ACC_W-1:0] sum_x, sum_y;
    logic signed [ACC_W-1:0] mean_x, mean_y;
    logic [8:0]        filt_x, filt_y;

    assign io_sel = (address_dmem[11:4] == IO_BASE);
    assign offset = address_dmem[3:0];

    assign ram_addr   = address_dmem;
    assign ram_dataIn = data;
    assign ram_wEn    = wren & ~io_sel;

    assign q_dmem = io_sel_q ? io_rdata_q : ram_dataOut;

    assign status_rd   = io_sel & (offset == REG_STATUS) & ~wren;
    assign frame_start = vs_q & ~vSync;

    assign sample_tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign win_last    = &win_cnt;

    // The closing sample of a window is folded into the mean directly, not via the accumulator.
    assign sum_x  = acc_x + {{AVG_LOG2{accel_x_in[8]}}, accel_x_in};
    assign sum_y  = acc_y + {{AVG_LOG2{accel_y_in[8]}}, accel_y_in};
    assign mean_x = sum_x >>> AVG_LOG2;
    assign mean_y = sum_y >>> AVG_LOG2;

    always_comb begin
        io_rdata = '0;
        case (offset)
            REG_ACCEL_X: io_rdata = {{23{filt_x[8]}}, filt_x};
            REG_ACCEL_Y: io_rdata = {{23{filt_y[8]}}, filt_y};
            REG_STATUS:  io_rdata = {30'd0, valid, frame};
            REG_SQ_X:    io_rdata = {22'd0, sq_x};
            REG_SQ_Y:    io_rdata = {23'd0, sq_y};
            default:     io_rdata = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            io_sel_q   <= 1'b0;
            io_rdata_q <= '0;
        end else begin
            io_sel_q   <= io_sel;
            io_rdata_q <= io_rdata;
        end
    end

    // A frame start outranks a simultaneous STATUS read so no frame is ever lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            vs_q  <= 1'b0;
            frame <= 1'b0;
        end else begin
            vs_q <= vSync;
            if (frame_start) begin
                frame <= 1'b1;
            end else if (status_rd) begin
                frame <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sq_x <= 10'd316;
            sq_y <= 9'd236;
        end else if (wren && io_sel) begin
            if (offset == REG_SQ_X) begin
                sq_x <= data[9:0];
            end
            if (offset == REG_SQ_Y) begin
                sq_y <= data[8:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (sample_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            win_cnt <= '0;
            acc_x   <= '0;
            acc_y   <= '0;
            filt_x  <= '0;
            filt_y  <= '0;
            valid   <= 1'b0;
        end else if (sample_tick) begin
            win_cnt <= win_cnt + AVG_LOG2'(1);
            if (win_last) begin
                filt_x <= mean_x[8:0];
                filt_y <= mean_y[8:0];
                acc_x  <= '0;
                acc_y  <= '0;
                valid  <= 1'b1;
            end else begin
                acc_x <= sum_x;
                acc_y <= sum_y;
            end
        end
    end

endmodule

// File: tb/tb_dmem_io_bridge.sv
// Self-checking bench for dmem_io_bridge: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the register map, RAM and filter.
module tb_dmem_io_bridge;
    localparam int unsigned DIV  = 4;
    localparam int unsigned LOG2 = 3;
    localparam int         WIN  = 1 << LOG2;

    logic        clock;
    logic        reset;
    logic        wren;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic [31:0] q_dmem;
    logic        ram_wEn;
    logic [11:0] ram_addr;
    logic [31:0] ram_dataIn;
    logic [31:0] ram_dataOut;
    logic [8:0]  accel_x_in;
    logic [8:0]  accel_y_in;
    logic        vSync;
    logic [9:0]  sq_x;
    logic [8:0]  sq_y;

    int n_checks = 0;
    int n_errors = 0;

    dmem_io_bridge #(
        .IO_BASE   (8'hFF),
        .SAMPLE_DIV(DIV),
        .AVG_LOG2  (LOG2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wren        (wren),
        .address_dmem(address_dmem),
        .data        (data),
        .q_dmem      (q_dmem),
        .ram_wEn     (ram_wEn),
        .ram_addr    (ram_addr),
        .ram_dataIn  (ram_dataIn),
        .ram_dataOut (ram_dataOut),
        .accel_x_in  (accel_x_in),
        .accel_y_in  (accel_y_in),
        .vSync       (vSync),
        .sq_x        (sq_x),
        .sq_y        (sq_y)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous RAM with one cycle read latency, read-before-write.
    logic [31:0] mem [4096];
    always @(posedge clock) begin
        if (ram_wEn) mem[ram_addr] <= ram_dataIn;
        ram_dataOut <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (owned by the compare process) ----------------
    logic [31:0] shadow [4096];
    bit          known  [4096];
    int          m_cyc;
    int          win_x[$];
    int          win_y[$];
    int          m_fx, m_fy;
    bit          m_valid, m_frame, m_vs;
    logic [9:0]  m_sqx;
    logic [8:0]  m_sqy;

    function automatic int floor_div(input int s, input int n);
        int r;
        r = s / n;
        if ((s % n) != 0 && s < 0) r = r - 1;
        return r;
    endfunction

    function automatic logic [31:0] reg_read(input logic [3:0] off);
        case (off)
            4'h0:    return m_fx;
            4'h1:    return m_fy;
            4'h2:    return {30'd0, m_valid, m_frame};
            4'h3:    return {22'd0, m_sqx};
            4'h4:    return {23'd0, m_sqy};
            default: return 32'd0;
        endcase
    endfunction

    initial begin : compare
        logic [31:0] exp_q;
        bit          exp_known;
        bit          io;
        int          s;
        for (int i = 0; i < 4096; i++) known[i] = 1'b0;
        m_cyc = 0; m_fx = 0; m_fy = 0; m_valid = 0; m_frame = 0; m_vs = 0;
        m_sqx = 10'd316; m_sqy = 9'd236;
        exp_q = '0; exp_known = 0;
        forever begin
            @(negedge clock);
            io = (address_dmem[11:4] == 8'hFF);
            chk("ram_wEn",    {31'd0, ram_wEn}, {31'd0, wren && !io});
            chk("ram_addr",   {20'd0, ram_addr}, {20'd0, address_dmem});
            chk("ram_dataIn", ram_dataIn, data);
            chk("sq_x",       {22'd0, sq_x}, {22'd0, m_sqx});
            chk("sq_y",       {23'd0, sq_y}, {23'd0, m_sqy});
            if (exp_known) chk("q_dmem", q_dmem, exp_q);

            // what the coming edge must produce
            if (io && !reset) begin
                exp_q = reg_read(address_dmem[3:0]);
                exp_known = 1;
            end else begin
                exp_q = shadow[address_dmem];
                exp_known = known[address_dmem];
            end
            if (wren && !io) begin
                shadow[address_dmem] = data;
                known[address_dmem] = 1;
            end
            if (reset) begin
                m_cyc = 0; m_fx = 0; m_fy = 0; m_valid = 0; m_frame = 0; m_vs = 0;
                m_sqx = 10'd316; m_sqy = 9'd236;
                win_x.delete(); win_y.delete();
            end else begin
                if (io && !wren && address_dmem[3:0] == 4'h2) m_frame = 0;
                if (m_vs && !vSync) m_frame = 1;
                m_vs = vSync;
                if (io && wren && address_dmem[3:0] == 4'h3) m_sqx = data[9:0];
                if (io && wren && address_dmem[3:0] == 4'h4) m_sqy = data[8:0];
                if ((m_cyc % DIV) == DIV - 1) begin
                    win_x.push_back(int'($signed(accel_x_in)));
                    win_y.push_back(int'($signed(accel_y_in)));
                    if (win_x.size() == WIN) begin
                        s = 0;
                        foreach (win_x[j]) s += win_x[j];
                        m_fx = floor_div(s, WIN);
                        s = 0;
                        foreach (win_y[j]) s += win_y[j];
                        m_fy = floor_div(s, WIN);
                        win_x.delete(); win_y.delete();
                        m_valid = 1;
                    end
                end
                m_cyc++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wren = 1'b0;
        address_dmem = 12'h000;
        data = '0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        address_dmem = a; data = d; wren = 1'b1;
        step();
        idle();
    endtask

    task automatic rd(input logic [11:0] a, input string name, input logic [31:0] mask,
                      input logic [31:0] exp);
        address_dmem = a; wren = 1'b0;
        step();
        chk(name, q_dmem & mask, exp);
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin : stimulus
        reset = 1'b1; vSync = 1'b1; accel_x_in = '0; accel_y_in = '0;
        idle();
        do_reset();
        chk("reset_sq_x", {22'd0, sq_x}, 32'd316);
        chk("reset_sq_y", {23'd0, sq_y}, 32'd236);
        rd(12'hFF2, "reset_status", '1, 32'h0);
        rd(12'hFF0, "reset_accel_x", '1, 32'h0);

        for (int i = 0; i < 16; i++) wr(12'(i), $urandom);

        address_dmem = 12'h010; data = 32'h1234; wren = 1'b1;
        #1 chk("ram_write_wen", {31'd0, ram_wEn}, 32'd1);
        step();
        idle();
        #1 chk("ram_idle_wen", {31'd0, ram_wEn}, 32'd0);
        rd(12'h010, "ram_readback", '1, 32'h1234);

        address_dmem = 12'hFF3; data = 32'hFFFFFC05; wren = 1'b1;
        #1 chk("io_write_no_ram", {31'd0, ram_wEn}, 32'd0);
        step();
        chk("sq_x_written", {22'd0, sq_x}, 32'h5);
        idle();
        rd(12'hFF3, "sq_x_read", '1, 32'h5);

        vSync = 1'b0;
        step();
        vSync = 1'b1;
        rd(12'hFF2, "frame_set", 32'h1, 32'h1);
        rd(12'hFF2, "frame_cleared", 32'h1, 32'h0);
        step();
        address_dmem = 12'hFF2; wren = 1'b0; vSync = 1'b0;
        step();
        chk("frame_coincide_old", q_dmem & 32'h1, 32'h0);
        vSync = 1'b1;
        idle();
        rd(12'hFF2, "frame_set_wins", 32'h1, 32'h1);
        rd(12'hFF2, "frame_after_read", 32'h1, 32'h0);

        accel_x_in = 9'h1F6; accel_y_in = 9'h005;
        do_reset();
        repeat (31) step();
        rd(12'hFF2, "valid_before_32", 32'h2, 32'h0);
        rd(12'hFF2, "valid_at_32", 32'h2, 32'h2);
        rd(12'hFF0, "accel_x_const", '1, 32'hFFFFFFF6);
        rd(12'hFF1, "accel_y_const", '1, 32'h5);

        do_reset();
        for (int k = 0; k < 8; k++) begin
            accel_x_in = 9'(k);
            accel_y_in = 9'(-k);
            repeat (4) step();
        end
        rd(12'hFF0, "accel_x_ramp", '1, 32'h3);
        rd(12'hFF1, "accel_y_ramp_floor", '1, 32'hFFFFFFFC);

        accel_x_in = 9'd100;
        do_reset();
        repeat (20) step();
        accel_x_in = 9'd20;
        do_reset();
        rd(12'hFF0, "midwin_reset_accel", '1, 32'h0);
        rd(12'hFF2, "midwin_reset_valid", 32'h2, 32'h0);
        repeat (30) step();
        rd(12'hFF0, "post_reset_window", '1, 32'd20);
        rd(12'hFF1, "post_reset_window_y", '1, 32'hFFFFFFF9);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            wren = ($urandom_range(0, 2) == 0);
            address_dmem = ($urandom_range(0, 1) == 1) ? {8'hFF, 4'($urandom)}
                                                        : {8'h00, 4'($urandom)};
            data = $urandom;
            accel_x_in = 9'($urandom);
            accel_y_in = 9'($urandom);
            if ($urandom_range(0, 7) == 0) vSync = ~vSync;
            step();
        end
        reset = 1'b0;
        idle();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_io_bridge.md
Name: dmem_io_bridge

Overview:
- Sits on the processor data-memory bus, between the CPU and the RAM.
- Decodes each address and forwards it either to the RAM or to a small bank of memory-mapped IO registers.
- The IO registers hold: box-car-filtered accelerometer X/Y, a frame-start flag derived from VGA vSync, and CPU-written square-position registers consumed by the VGA controller.
- Lets game code poll tilt and frame timing with plain lw/sw.

Parameters:
- IO_BASE, 8'hFF: address bits [11:4] that select the IO region (0xFF0–0xFFF).
- SAMPLE_DIV, 50000: clock cycles between accelerometer samples (1 kHz at 50 MHz); must be at least 2.
- AVG_LOG2, 3: log2 of the filter window (8 samples).

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- wren  in  1  CPU data-memory write enable
- address_dmem  in  12  CPU data address (memAddr[11:0])
- data  in  32  CPU write data
- q_dmem  out  32  read data to CPU
- ram_wEn  out  1  RAM write enable
- ram_addr  out  12  RAM address
- ram_dataIn  out  32  RAM write data
- ram_dataOut  in  32  RAM read data (registered, 1-cycle latency)
- accel_x_in  in  9  raw accelerometer X, two's complement
- accel_y_in  in  9  raw accelerometer Y, two's complement
- vSync  in  1  VGA vertical sync, active-low, same clock domain
- sq_x  out  10  square X position to VGA
- sq_y  out  9  square Y position to VGA

Behaviour:
- Decode: io_sel = (address_dmem[11:4] == IO_BASE), combinational.
- RAM passthrough:
  - ram_addr = address_dmem; ram_dataIn = data.
  - ram_wEn = wren & ~io_sel. An IO write never reaches the RAM.
- Read path has 1-cycle latency, matching the RAM:
  - io_sel_q and the IO read data are registered on every clock.
  - q_dmem = io_sel_q ? io_rdata_q : ram_dataOut.
  - Reset clears io_sel_q and io_rdata_q, so q_dmem follows ram_dataOut after reset.
- Register map (offset = address_dmem[3:0]):
  - 0x0 ACCEL_X, RO: filtered X, sign-extended to 32 bits.
  - 0x1 ACCEL_Y, RO: filtered Y, sign-extended to 32 bits.
  - 0x2 STATUS, RO: bit0 FRAME (sticky), bit1 VALID (set at the first completed window). Other bits read 0.
  - 0x3 SQ_X, RW: bits[9:0]. Upper write bits are ignored; reads zero-extend.
  - 0x4 SQ_Y, RW: bits[8:0]. Same rules as SQ_X.
  - 0x5–0xF: reads return 0, writes are ignored.
- Read-side effect: a read of STATUS is any cycle with io_sel=1, offset=2, wren=0. It clears FRAME in the same edge that captures io_rdata_q, so the CPU sees the pre-clear value.
- FRAME set/clear:
  - A frame start is a 1→0 transition of vSync, detected against a registered copy vs_q.
  - A frame start sets FRAME.
  - If a frame start and a STATUS read occur in the same cycle, set wins: FRAME=1 afterwards.
- Sample timer:
  - div_cnt counts 0..SAMPLE_DIV-1 and wraps.
  - sample_tick = (div_cnt == SAMPLE_DIV-1).
- Filter:
  - Two signed accumulators, each (9+AVG_LOG2) bits wide, plus a window counter win_cnt of AVG_LOG2 bits.
  - On sample_tick: acc += sign-extended raw sample; win_cnt++.
  - When win_cnt wraps from 2^AVG_LOG2-1 to 0:
    - filt_x/filt_y ← (acc + sample) >>> AVG_LOG2, arithmetic shift, truncating toward −∞.
    - acc ← 0.
    - VALID ← 1, and it stays set until reset.
  - No overflow is possible: ±256·2^AVG_LOG2 fits in the accumulator width.
- SQ_X/SQ_Y: written on the clock edge where wren & io_sel & matching offset. sq_x/sq_y drive directly from these registers.
- Reset values:
  - div_cnt, win_cnt, accumulators, filt_x, filt_y, FRAME, VALID, vs_q: 0.
  - SQ_X = 10'd316, SQ_Y = 9'd236 (screen-centred 8-px square).
  - q_dmem = ram_dataOut.
- Reset mid-window: the partial accumulation is discarded and filt_* return to 0.
- Simultaneous write to SQ_X with a read of the same address: the read returns the old value (registered read), and the new value is visible on the next read.

Test Plan:
- Reset → sq_x=316, sq_y=236; a STATUS read returns 0; an ACCEL_X read returns 0.
- sw 0x1234 to 0x010 (RAM), then lw 0x010 → q_dmem=0x1234 one cycle later; ram_wEn was high only during the write.
- sw 0xFFFFFC05 to 0xFF3 → sq_x=10'h005, ram_wEn stays 0; lw 0xFF3 → 0x00000005.
- SAMPLE_DIV=4, AVG_LOG2=3, accel_x_in held at 9'h1F6 (−10) for 8 ticks → ACCEL_X=0xFFFFFFF6 and VALID=1 exactly 32 cycles after reset release. Samples 0..7 give mean 3.5 → ACCEL_X=3.
- vSync 1→0 → the next STATUS read returns bit0=1; a second read returns bit0=0. A vSync fall coinciding with a STATUS read leaves FRAME=1.
- Assert reset after 5 of 8 samples → ACCEL_X=0 and VALID=0; the next full window yields the correct mean from post-reset samples only.
